serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial full adder: the addition counterpart of the team's full subtractor cell.
- Adds two WIDTH-bit operands plus an input carry, one bit per clock, LSB first, using a single full-add cell and a carry flip-flop.
- Start/Busy/Done handshake; used where area matters more than latency, e.g. a shared arithmetic path in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- Clock  input  1  rising-edge clock; single clock domain.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; sampled on the accepted Start edge.
- B  input  WIDTH  operand B; sampled on the accepted Start edge.
- Carry_In  input  1  input carry; sampled on the accepted Start edge.
- Sum  output  WIDTH  result register, A+B+Carry_In mod 2^WIDTH.
- Carry_Out  output  1  carry out of the MSB.
- Overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse; result registers have just been updated.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - Next edge with Reset=1 forces state=IDLE, Sum=0, Carry_Out=0, Overflow=0, Busy=0, Done=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset mid-operation aborts the operation with no Done and no result update.
- FSM states: IDLE, ADD, FIN.
- IDLE:
  - Start=1 at edge k: load A, B into internal shift registers, carry flop <= Carry_In, bit counter <= 0, state <= ADD.
  - Start=0: stay in IDLE.
- ADD, edges k+1 .. k+WIDTH, one bit per edge:
  - s = a0 XOR b0 XOR c.
  - c' = a0·b0 + a0·c + b0·c.
  - s shifts into the internal result shift register from the MSB side.
  - Operand registers shift right; carry flop <= c'; counter increments.
  - On the edge processing bit WIDTH-1: the carry before that bit is captured for Overflow, and state <= FIN.
- FIN (the cycle after edge k+WIDTH):
  - Sum, Carry_Out and Overflow were loaded on edge k+WIDTH and hold until the next completion.
  - Done=1 for exactly this one cycle; next edge state <= IDLE.
- Busy = 1 exactly when state=ADD, i.e. the WIDTH cycles following edges k .. k+WIDTH-1.
- Latency: Start accepted at edge k; Done high in the cycle after edge k+WIDTH. Minimum Start-to-Start spacing is WIDTH+2 edges.
- Start while in ADD or FIN is ignored and does not queue. Start held high continuously restarts on the first edge back in IDLE.
- A, B and Carry_In may change freely after the accepted Start edge without affecting the result.
- Sum, Carry_Out and Overflow never show partial results; they keep the previous result during an operation.
- Counter width is clog2(WIDTH); it does not wrap during a valid operation.

Test Plan:
- Reset, then idle for 5 cycles -> Sum=0x00, Carry_Out=0, Overflow=0, Busy=0, Done=0 throughout.
- WIDTH=8, A=0x35, B=0x4A, Carry_In=0, Start pulse at edge k -> Busy high for 8 cycles, Done pulse after edge k+8, Sum=0x7F, Carry_Out=0, Overflow=0.
- A=0xFF, B=0x01, Carry_In=0 -> Sum=0x00, Carry_Out=1, Overflow=0. Then A=0x7F, B=0x01 -> Sum=0x80, Carry_Out=0, Overflow=1.
- A=0xFF, B=0x00, Carry_In=1 -> Sum=0x00, Carry_Out=1. A=0x80, B=0x80, Carry_In=0 -> Sum=0x00, Carry_Out=1, Overflow=1.
- Start A=0x10, B=0x20; change A/B and pulse Start again during ADD and during FIN -> single Done, Sum=0x30. A new Start in the following IDLE cycle is accepted.
- Complete A=0x01, B=0x01 (Sum=0x02). Then start A=0x35, B=0x4A and assert Reset at edge k+4 -> no Done, Busy=0, Sum=0x00 after reset. A subsequent operation completes normally.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell plus a carry flop, LSB first, WIDTH+1 cycles per add.
// Start/Busy/Done handshake; result registers only change on completion.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_in_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_out_o,
   output logic             overflow_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned RES_W = WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               c_q, c_d;
   logic [RES_W-1:0]   res_q, res_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               sum_bit;
   logic               carry_nxt;
   logic               last_bit;

   // Single full-add cell shared across all bit positions.
   assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
   assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               c_d     = carry_in_i;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            c_d = carry_nxt;
            // Sum bits enter from the MSB side; the final bit completes the word directly.
            res_d = RES_W'({sum_bit, res_q} >> 1);
            if (last_bit) begin
               sum_d   = {sum_bit, res_q};
               cout_d  = carry_nxt;
               ovf_d   = c_q ^ carry_nxt;
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               busy_d = 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sum_o       = sum_q;
   assign carry_out_o = cout_q;
   assign overflow_o  = ovf_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random operands,
// expected results queued at issue time and checked by an independent Done monitor.
module tb_serial_adder;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;
   logic         done;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic [W-1:0] last_sum;

   serial_adder #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .a_i         (a),
      .b_i         (b),
      .carry_in_i  (cin),
      .sum_o       (sum),
      .carry_out_o (cout),
      .overflow_o  (ovf),
      .busy_o      (busy),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference: plain integer addition; overflow from operand/result sign rule.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0] full;
      exp_t       e;
      full   = (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      return e;
   endfunction

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done !== 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sum", 32'(sum), 32'(e.sum));
               chk("carry_out", 32'(cout), 32'(e.cout));
               chk("overflow", 32'(ovf), 32'(e.ovf));
            end
         end
      end
   end

   // Wait (bounded) for a Done pulse; current time is a negedge.
   task automatic wait_done(input string name);
      bit found = 0;
      for (int i = 0; i < 3 * W && !found; i++) begin
         @(negedge clk);
         if (done === 1'b1) found = 1;
      end
      if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   // One complete operation with latency, Busy width and result-hold checks.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      exp_t e;
      int   busy_cnt = 0;
      int   done_at  = -1;
      e = model(x, y, ci);
      @(negedge clk);
      a = x; b = y; cin = ci; start = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom);
      for (int i = 1; i <= W + 4 && done_at < 0; i++) begin
         if (i > 1) @(negedge clk);
         if (busy === 1'b1) begin
            busy_cnt++;
            if (sum !== last_sum) chk("sum_hold", 32'(sum), 32'(last_sum));
         end
         if (done === 1'b1) done_at = i;
      end
      chk("done_latency", 32'(done_at), 32'(W + 1));
      chk("busy_cycles", 32'(busy_cnt), 32'(W));
      last_sum = e.sum;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      last_sum = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: all outputs quiet.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_sum", 32'(sum), 32'd0);
         chk("rst_cout", 32'(cout), 32'd0);
         chk("rst_ovf", 32'(ovf), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
      end

      // Directed corner cases.
      do_op(8'h35, 8'h4A, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0);
      do_op(8'hFF, 8'h00, 1'b1);
      do_op(8'h80, 8'h80, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1);

      // Start during ADD and FIN is ignored; Start in the next IDLE cycle is taken.
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      exp_q.push_back(model(8'h10, 8'h20, 1'b0));
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy_start", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      wait_done("ign_first");
      a = 8'hEE; b = 8'h11; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("ign_idle_done", 32'(done), 32'd0);
      chk("ign_idle_busy", 32'(busy), 32'd0);
      chk("ign_idle_sum", 32'(sum), 32'h30);
      a = 8'h03; b = 8'h04; cin = 1'b0;
      exp_q.push_back(model(8'h03, 8'h04, 1'b0));
      @(negedge clk);
      start = 1'b0;
      chk("ign_restart_busy", 32'(busy), 32'd1);
      wait_done("ign_second");
      last_sum = 8'h07;

      // Reset in mid-operation aborts without Done or result update.
      do_op(8'h01, 8'h01, 1'b0);
      @(negedge clk);
      a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      chk("abort_sum_before", 32'(sum), 32'h02);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (done !== 1'b0) chk("abort_no_done", 32'(done), 32'd0);
      end
      last_sum = '0;
      do_op(8'h12, 8'h34, 1'b1);

      // Random operands.
      for (int i = 0; i < 30; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
